// File: rtl/parameter_pkg.sv
// Shared architectural constants: major opcodes and reservation-station count.
package parameter_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam int unsigned RS_COUNT = 3;

endpackage

// File: rtl/typedef_pkg.sv
// Shared types: renamed instruction word, reservation-station class and its decode.
package typedef_pkg;
  import parameter_pkg::*;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [5:0] src1_tag;
    logic [5:0] src2_tag;
    logic [7:0] imm;
  } instruction_t;

  typedef enum logic [1:0] {
    RS_ALU = 2'd0,
    RS_LSU = 2'd1,
    RS_BRU = 2'd2
  } rs_class_e;

  function automatic rs_class_e decode_rs_class(input logic [6:0] opcode);
    case (opcode)
      OPC_LOAD, OPC_STORE:          return RS_LSU;
      OPC_BRANCH, OPC_JAL, OPC_JALR: return RS_BRU;
      default:                      return RS_ALU;
    endcase
  endfunction

  function automatic logic [2:0] rs_onehot(input rs_class_e c);
    return 3'b001 << c;
  endfunction

endpackage

// File: rtl/rs_credit_counter.sv
// Free-entry counter for one reservation station; saturates and latches an error on over/underflow.
module rs_credit_counter #(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned CW          = $clog2(NUM_ENTRIES) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [1:0]    take,
  input  logic          ret,
  output logic [CW-1:0] credit,
  output logic          err
);

  localparam logic [CW-1:0]        FULL   = CW'(NUM_ENTRIES);
  localparam logic signed [CW+1:0] FULL_S = (CW+2)'(NUM_ENTRIES);

  logic signed [CW+1:0] sum;
  logic [CW-1:0]        credit_next;
  logic                 err_next;

  always_comb begin
    sum         = $signed({2'b00, credit}) - $signed({{CW{1'b0}}, take})
                + $signed({{(CW+1){1'b0}}, ret});
    credit_next = sum[CW-1:0];
    err_next    = err;
    if (flush) begin
      credit_next = FULL;
    end else if (sum[CW+1]) begin
      credit_next = '0;
      err_next    = 1'b1;
    end else if (sum > FULL_S) begin
      credit_next = FULL;
      err_next    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit <= FULL;
      err    <= 1'b0;
    end else begin
      credit <= credit_next;
      err    <= err_next;
    end
  end

endmodule

// File: rtl/rs_dispatch_ctrl.sv
// Two-wide in-order dispatch into ALU/LSU/BRU reservation stations under credit flow control.
module rs_dispatch_ctrl
  import parameter_pkg::*;
  import typedef_pkg::*;
#(
  parameter int unsigned NUM_RS_ENTRIES = 8,
  parameter int unsigned ROB_WIDTH      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  instruction_t         in_instruction_0,
  input  instruction_t         in_instruction_1,
  input  logic [ROB_WIDTH-1:0] in_rob_id_0,
  input  logic [ROB_WIDTH-1:0] in_rob_id_1,
  input  logic                 in_valid_0,
  input  logic                 in_valid_1,
  output logic                 accept_0,
  output logic                 accept_1,
  input  logic [2:0]           issue_valid,
  output instruction_t         dispatch_instruction_0,
  output instruction_t         dispatch_instruction_1,
  output logic [ROB_WIDTH-1:0] dispatch_rob_id_0,
  output logic [ROB_WIDTH-1:0] dispatch_rob_id_1,
  output logic [2:0]           dispatch_sel_0,
  output logic [2:0]           dispatch_sel_1,
  output logic [31:0]          stall_cycles,
  output logic                 credit_err
);

  localparam int unsigned CW = $clog2(NUM_RS_ENTRIES) + 1;

  rs_class_e     cls0, cls1;
  logic [CW-1:0] credit [RS_COUNT];
  logic          err_vec [RS_COUNT];
  logic [1:0]    take [RS_COUNT];
  logic [CW-1:0] need_1;

  // Slot 1 must see room for both slots when they target the same station.
  always_comb begin
    cls0     = decode_rs_class(in_instruction_0.opcode);
    cls1     = decode_rs_class(in_instruction_1.opcode);
    need_1   = (cls1 == cls0) ? CW'(2) : CW'(1);
    accept_0 = rst_n & in_valid_0 & ~flush & (credit[cls0] != '0);
    accept_1 = accept_0 & in_valid_1 & (credit[cls1] >= need_1);
    for (int unsigned k = 0; k < RS_COUNT; k++) begin
      take[k] = {1'b0, accept_0 && (int'(cls0) == int'(k))}
              + {1'b0, accept_1 && (int'(cls1) == int'(k))};
    end
  end

  rs_credit_counter #(.NUM_ENTRIES(NUM_RS_ENTRIES), .CW(CW)) u_credit_alu (
    .clk(clk), .rst_n(rst_n), .flush(flush), .take(take[0]), .ret(issue_valid[0]),
    .credit(credit[0]), .err(err_vec[0])
  );

  rs_credit_counter #(.NUM_ENTRIES(NUM_RS_ENTRIES), .CW(CW)) u_credit_lsu (
    .clk(clk), .rst_n(rst_n), .flush(flush), .take(take[1]), .ret(issue_valid[1]),
    .credit(credit[1]), .err(err_vec[1])
  );

  rs_credit_counter #(.NUM_ENTRIES(NUM_RS_ENTRIES), .CW(CW)) u_credit_bru (
    .clk(clk), .rst_n(rst_n), .flush(flush), .take(take[2]), .ret(issue_valid[2]),
    .credit(credit[2]), .err(err_vec[2])
  );

  assign credit_err = err_vec[0] | err_vec[1] | err_vec[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dispatch_sel_0         <= '0;
      dispatch_sel_1         <= '0;
      dispatch_instruction_0 <= '0;
      dispatch_instruction_1 <= '0;
      dispatch_rob_id_0      <= '0;
      dispatch_rob_id_1      <= '0;
    end else if (flush) begin
      dispatch_sel_0 <= '0;
      dispatch_sel_1 <= '0;
    end else begin
      dispatch_sel_0 <= accept_0 ? rs_onehot(cls0) : '0;
      dispatch_sel_1 <= accept_1 ? rs_onehot(cls1) : '0;
      if (accept_0) begin
        dispatch_instruction_0 <= in_instruction_0;
        dispatch_rob_id_0      <= in_rob_id_0;
      end
      if (accept_1) begin
        dispatch_instruction_1 <= in_instruction_1;
        dispatch_rob_id_1      <= in_rob_id_1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (in_valid_0 && !accept_0) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_rs_dispatch_ctrl.sv
// Scoreboard bench for rs_dispatch_ctrl: a credit model predicts accepts and the dispatched words.
module tb_rs_dispatch_ctrl;
  import parameter_pkg::*;
  import typedef_pkg::*;

  localparam int N  = 8;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst_n, flush;
  instruction_t  in_instruction_0, in_instruction_1;
  logic [RW-1:0] in_rob_id_0, in_rob_id_1;
  logic          in_valid_0, in_valid_1;
  logic          accept_0, accept_1;
  logic [2:0]    issue_valid;
  instruction_t  dispatch_instruction_0, dispatch_instruction_1;
  logic [RW-1:0] dispatch_rob_id_0, dispatch_rob_id_1;
  logic [2:0]    dispatch_sel_0, dispatch_sel_1;
  logic [31:0]   stall_cycles;
  logic          credit_err;

  rs_dispatch_ctrl #(.NUM_RS_ENTRIES(N), .ROB_WIDTH(RW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_instruction_0(in_instruction_0), .in_instruction_1(in_instruction_1),
    .in_rob_id_0(in_rob_id_0), .in_rob_id_1(in_rob_id_1),
    .in_valid_0(in_valid_0), .in_valid_1(in_valid_1),
    .accept_0(accept_0), .accept_1(accept_1), .issue_valid(issue_valid),
    .dispatch_instruction_0(dispatch_instruction_0), .dispatch_instruction_1(dispatch_instruction_1),
    .dispatch_rob_id_0(dispatch_rob_id_0), .dispatch_rob_id_1(dispatch_rob_id_1),
    .dispatch_sel_0(dispatch_sel_0), .dispatch_sel_1(dispatch_sel_1),
    .stall_cycles(stall_cycles), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    sel0, sel1;
    instruction_t  i0, i1;
    logic [RW-1:0] r0, r1;
  } exp_t;

  exp_t        sb[$];
  int          mcr[3];
  logic [31:0] mstall;
  bit          merr;
  int          seq;
  int          total, bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int cls_of(input logic [6:0] op);
    if (op == OPC_LOAD || op == OPC_STORE) return 1;
    if (op == OPC_BRANCH || op == OPC_JAL || op == OPC_JALR) return 2;
    return 0;
  endfunction

  function automatic instruction_t mk(input logic [6:0] op, input logic [7:0] tag);
    instruction_t i;
    i          = '0;
    i.opcode   = op;
    i.rd       = tag[4:0];
    i.src1_tag = tag[5:0] ^ 6'h2a;
    i.imm      = tag;
    return i;
  endfunction

  task automatic check_state();
    check("credit_alu", 64'(dut.u_credit_alu.credit), 64'(mcr[0]));
    check("credit_lsu", 64'(dut.u_credit_lsu.credit), 64'(mcr[1]));
    check("credit_bru", 64'(dut.u_credit_bru.credit), 64'(mcr[2]));
    check("stall_cycles", 64'(stall_cycles), 64'(mstall));
    check("credit_err", 64'(credit_err), 64'(merr));
  endtask

  task automatic cycle(input bit v0, input logic [6:0] op0, input bit v1,
                       input logic [6:0] op1, input logic [2:0] iv, input bit fl);
    int   c0, c1, n;
    bit   a0, a1;
    exp_t e;
    @(negedge clk);
    in_valid_0 = v0; in_instruction_0 = mk(op0, 8'(seq));     in_rob_id_0 = RW'(seq);
    in_valid_1 = v1; in_instruction_1 = mk(op1, 8'(seq + 1)); in_rob_id_1 = RW'(seq + 1);
    seq += 2;
    issue_valid = iv; flush = fl;
    #1;
    c0 = cls_of(op0); c1 = cls_of(op1);
    a0 = v0 && !fl && mcr[c0] >= 1;
    a1 = v1 && a0 && mcr[c1] >= ((c1 == c0) ? 2 : 1);
    check("accept_0", 64'(accept_0), 64'(a0));
    check("accept_1", 64'(accept_1), 64'(a1));
    e.sel0 = a0 ? (3'b001 << c0) : 3'b000;
    e.sel1 = a1 ? (3'b001 << c1) : 3'b000;
    e.i0 = in_instruction_0; e.r0 = in_rob_id_0;
    e.i1 = in_instruction_1; e.r1 = in_rob_id_1;
    sb.push_back(e);
    if (v0 && !a0) mstall++;
    for (int k = 0; k < 3; k++) begin
      if (fl) mcr[k] = N;
      else begin
        n = mcr[k] - int'(a0 && c0 == k) - int'(a1 && c1 == k) + int'(iv[k]);
        if (n > N) begin n = N; merr = 1'b1; end
        if (n < 0) begin n = 0; merr = 1'b1; end
        mcr[k] = n;
      end
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("dispatch_sel_0", 64'(dispatch_sel_0), 64'(e.sel0));
    check("dispatch_sel_1", 64'(dispatch_sel_1), 64'(e.sel1));
    if (e.sel0 != 3'b000) begin
      check("dispatch_instruction_0", 64'(dispatch_instruction_0), 64'(e.i0));
      check("dispatch_rob_id_0", 64'(dispatch_rob_id_0), 64'(e.r0));
    end
    if (e.sel1 != 3'b000) begin
      check("dispatch_instruction_1", 64'(dispatch_instruction_1), 64'(e.i1));
      check("dispatch_rob_id_1", 64'(dispatch_rob_id_1), 64'(e.r1));
    end
    check_state();
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) mcr[k] = N;
    mstall = '0;
    merr   = 1'b0;
    sb.delete();
  endtask

  // Reset asserted between the input change and the next edge, with traffic pending.
  task automatic mid_reset();
    @(negedge clk);
    in_valid_0 = 1'b1; in_instruction_0 = mk(OPC_OP, 8'hA5);
    in_valid_1 = 1'b1; in_instruction_1 = mk(OPC_LOAD, 8'h5A);
    issue_valid = 3'b000; flush = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("accept_0_in_reset", 64'(accept_0), 64'd0);
    check("accept_1_in_reset", 64'(accept_1), 64'd0);
    check("rst_sel_0", 64'(dispatch_sel_0), 64'd0);
    check("rst_sel_1", 64'(dispatch_sel_1), 64'd0);
    check("rst_instr_0", 64'(dispatch_instruction_0), 64'd0);
    check("rst_rob_1", 64'(dispatch_rob_id_1), 64'd0);
    model_reset();
    check_state();
    @(posedge clk);
    #1;
    check("rst_sel_0_after_edge", 64'(dispatch_sel_0), 64'd0);
    @(negedge clk);
    in_valid_0 = 1'b0; in_valid_1 = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops [8];
    total = 0; bad = 0; seq = 0;
    ops[0] = OPC_OP;   ops[1] = OPC_OP_IMM; ops[2] = OPC_LUI;  ops[3] = OPC_LOAD;
    ops[4] = OPC_STORE; ops[5] = OPC_BRANCH; ops[6] = OPC_JAL; ops[7] = OPC_JALR;
    rst_n = 1'b1; flush = 1'b0; issue_valid = '0;
    in_valid_0 = 1'b0; in_valid_1 = 1'b0;
    in_instruction_0 = '0; in_instruction_1 = '0; in_rob_id_0 = '0; in_rob_id_1 = '0;
    #2;
    mid_reset();

    // Mixed pair into two stations
    cycle(1, OPC_OP, 1, OPC_LOAD, 3'b000, 0);
    cycle(0, OPC_OP, 0, OPC_OP, 3'b000, 1);

    // Drain ALU, stall, then a returned credit is only usable next cycle
    repeat (4) cycle(1, OPC_OP, 1, OPC_OP_IMM, 3'b000, 0);
    repeat (3) cycle(1, OPC_OP, 0, OPC_OP, 3'b000, 0);
    cycle(1, OPC_OP, 0, OPC_OP, 3'b001, 0);
    cycle(1, OPC_OP, 0, OPC_OP, 3'b000, 0);

    // One credit left, same-class pair
    cycle(0, OPC_OP, 0, OPC_OP, 3'b001, 0);
    cycle(1, OPC_OP, 1, OPC_OP, 3'b000, 0);

    // BRU empty blocks slot 0 and therefore slot 1
    cycle(0, OPC_OP, 0, OPC_OP, 3'b000, 1);
    repeat (4) cycle(1, OPC_BRANCH, 1, OPC_JAL, 3'b000, 0);
    repeat (2) cycle(1, OPC_BRANCH, 1, OPC_OP, 3'b000, 0);

    // Build credits 3/5/2, then flush with returns in the same cycle
    cycle(0, OPC_OP, 0, OPC_OP, 3'b000, 1);
    cycle(1, OPC_OP, 1, OPC_OP, 3'b000, 0);
    cycle(1, OPC_OP, 1, OPC_OP, 3'b000, 0);
    cycle(1, OPC_OP, 1, OPC_LOAD, 3'b000, 0);
    cycle(1, OPC_LOAD, 1, OPC_STORE, 3'b000, 0);
    repeat (3) cycle(1, OPC_JALR, 1, OPC_BRANCH, 3'b000, 0);
    cycle(1, OPC_OP, 1, OPC_LOAD, 3'b111, 1);

    // Return into a full station, error stays through flush
    cycle(0, OPC_OP, 0, OPC_OP, 3'b001, 0);
    cycle(1, OPC_STORE, 1, OPC_JAL, 3'b000, 0);
    cycle(0, OPC_OP, 0, OPC_OP, 3'b000, 1);

    // Simultaneous take and return on the same station
    cycle(1, OPC_LOAD, 1, OPC_LOAD, 3'b010, 0);

    mid_reset();
    for (int i = 0; i < 60; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), ops[$urandom_range(0, 7)],
            1'($urandom_range(0, 1)), ops[$urandom_range(0, 7)],
            3'($urandom_range(0, 7) & $urandom_range(0, 7)),
            1'($urandom_range(0, 19) == 0));
    end
    mid_reset();
    cycle(1, OPC_JAL, 1, OPC_STORE, 3'b000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs_dispatch_ctrl.md
RS_DISPATCH_CTRL -- requirements
Module: rs_dispatch_ctrl

Interface
REQ-001 SHALL have parameter NUM_RS_ENTRIES, default 8, entries per reservation station (ALU, LSU, BRU identical).
REQ-002 SHALL have parameter ROB_WIDTH, default 4, ROB id width.
REQ-003 SHALL have one clock and asynchronous active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  async active-low reset.
REQ-004 SHALL have flush  in  1  pipeline flush, synchronous.
REQ-005 SHALL have in_instruction_0 / in_instruction_1  in  instruction_t  renamed instructions, slot 0 older.
REQ-006 SHALL have in_rob_id_0 / in_rob_id_1  in  ROB_WIDTH  ROB ids; in_valid_0 / in_valid_1  in  1  slot valid.
REQ-007 SHALL have accept_0 / accept_1  out  1  slot taken this cycle, combinational.
REQ-008 SHALL have issue_valid  in  3  per-RS issue pulse (bit0 ALU, bit1 LSU, bit2 BRU), one credit returned per bit.
REQ-009 SHALL have dispatch_instruction_0/1  out  instruction_t; dispatch_rob_id_0/1  out  ROB_WIDTH; registered.
REQ-010 SHALL have dispatch_sel_0 / dispatch_sel_1  out  3  one-hot target RS per slot, all-zero = no dispatch; registered.
REQ-011 SHALL have stall_cycles  out  32  count of cycles with in_valid_0=1 and accept_0=0.
REQ-012 SHALL have credit_err  out  1  sticky credit overflow/underflow flag.

Function
REQ-013 Class decode: LOAD, STORE -> LSU; BRANCH, JAL, JALR -> BRU; all other opcodes -> ALU.
REQ-014 Per-RS credit counter, width clog2(NUM_RS_ENTRIES)+1, = free RS entries.
REQ-015 accept_0 = in_valid_0 & !flush & credit[class0] >= 1.
REQ-016 accept_1 = in_valid_1 & accept_0 & credit[class1] >= (class1==class0 ? 2 : 1); in-order, slot 1 never accepted alone.
REQ-017 Accept decision uses registered credit only; credits returned by issue_valid in cycle N usable from cycle N+1.
REQ-018 credit_next[k] = credit[k] - accepted-to-k (0..2) + issue_valid[k]; simultaneous take/return both applied.
REQ-019 Dispatch latency one cycle: accepted slot appears on dispatch_* with its sel bit set at next rising edge.
REQ-020 Slot mapping preserved: accepted slot 0 drives dispatch_*_0, slot 1 drives dispatch_*_1, even if targeting different RSs.
REQ-021 Non-accepted slot: dispatch_sel = 0 next cycle; dispatch_instruction/rob_id don't-care.
REQ-022 Upstream re-presents a rejected instruction; block holds no instruction beyond the output register.
REQ-023 Flush: accept_0/1 = 0 same cycle; next edge all credits = NUM_RS_ENTRIES, dispatch_sel_0/1 = 0; issue_valid in flush cycle ignored.
REQ-024 Credit would exceed NUM_RS_ENTRIES or drop below 0: counter saturates, credit_err set until reset.
REQ-025 stall_cycles wraps at 2^32-1 -> 0; not cleared by flush.

Reset
REQ-026 rst_n low: credits = NUM_RS_ENTRIES, dispatch_sel_0/1 = 0, dispatch_instruction/rob_id = 0, stall_cycles = 0, credit_err = 0, asynchronously.
REQ-027 accept_0/1 = 0 while rst_n low; reset mid-operation discards in-flight dispatch without credit return.

Structure
REQ-028 Opcode constants and instruction_t reused from parameter_pkg / typedef_pkg; RS class enum (RS_ALU, RS_LSU, RS_BRU) added to typedef_pkg.
REQ-029 One sub-module rs_credit_counter (per-RS counter, saturation, error), instantiated three times.

Verification
REQ-030 After reset, OP + LOAD both valid -> accept_0=1, accept_1=1; next cycle dispatch_sel_0=001, dispatch_sel_1=010; ALU, LSU credits 7.
REQ-031 8 accepted OP slots, no issue -> ALU credit 0; next OP rejected, stall_cycles +1 per cycle; issue_valid=001 -> accepted following cycle.
REQ-032 ALU credit 1, two OP slots -> accept_0=1, accept_1=0; credit 0.
REQ-033 BRU credit 0, slot 0 BRANCH, slot 1 OP -> both rejected, stall_cycles increments.
REQ-034 Credits 3/5/2, flush with issue_valid=111 -> next cycle all credits 8, dispatch_sel 0, credit_err 0.
REQ-035 issue_valid=001 at ALU credit 8 -> credit stays 8, credit_err=1 until rst_n low.
